issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter: PHY_RF_DEPTH, 16, number of physical registers; tag width TW = $clog2(PHY_RF_DEPTH).
REQ-002 Parameter: IQ_DEPTH, 8, queue entries; power of two, >= 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: en  input  1  stage enable; 0 freezes enqueue and issue.
REQ-006 Port: uop_in  input  uop_t  renamed uop from map; uop_ic.rs1/rs2 hold physical tags (low TW bits), with rs1_valid/rs2_valid.
REQ-007 Port: uop_in_valid  input  1  uop_in carries a uop this cycle.
REQ-008 Port: full  output  1  queue holds IQ_DEPTH entries; map must stall.
REQ-009 Port: busy_table_wr_en  input  1  from map: mark busy_table_wr_addr busy.
REQ-010 Port: busy_table_wr_addr  input  TW  physical tag to mark busy.
REQ-011 Port: wb_en  input  1  writeback broadcast: clear busy bit of wb_addr.
REQ-012 Port: wb_addr  input  TW  physical tag being written back.
REQ-013 Port: uop_out  output  uop_t  issued uop (registered).
REQ-014 Port: uop_out_valid  output  1  uop_out holds an issued uop.
REQ-015 Port: exec_ready  input  1  execute stage accepts uop_out this cycle.

Function
REQ-016 Storage: circular FIFO of IQ_DEPTH uop_t entries; head/tail pointers TW_Q = $clog2(IQ_DEPTH) bits, wrap modulo IQ_DEPTH; count register TW_Q+1 bits.
REQ-017 full SHALL be combinational from registered count: full = (count == IQ_DEPTH).
REQ-018 Enqueue at edge when en & uop_in_valid & !full: entry[tail] <= uop_in, tail++ ; uop_in_valid while full is dropped, no state change.
REQ-019 Busy table: PHY_RF_DEPTH bits, internal; set on busy_table_wr_en, cleared on wb_en; updates occur regardless of en.
REQ-020 Simultaneous set and clear of same tag: set wins (bit = 1); different tags: both applied.
REQ-021 Tag 0 is never busy: set of tag 0 ignored; bit 0 reads 0 always.
REQ-022 Source ready = !rsX_valid | !busy[tag] | (wb_en & wb_addr == tag) (same-cycle writeback bypass).
REQ-023 Head issues in order only; head issues when count != 0, en, rs1 ready, rs2 ready, and output slot free (!uop_out_valid | exec_ready).
REQ-024 On issue: uop_out <= entry[head], uop_out_valid <= 1, head++, count--.
REQ-025 No issue but exec_ready & uop_out_valid: uop_out_valid <= 0; uop_out holds last value.
REQ-026 Not-ready head blocks all younger entries (no out-of-order bypass).
REQ-027 Enqueue and issue same edge: count unchanged, both pointers advance; entering uop is not eligible for issue until following edge.
REQ-028 Empty-queue enqueue: minimum latency uop_in_valid sampled at edge E -> uop_out_valid high after edge E+1.
REQ-029 en = 0: no enqueue, no issue, uop_out/uop_out_valid hold even if exec_ready = 1.
REQ-030 Sustained throughput: one issue per cycle when head ready and exec_ready = 1.

Reset
REQ-031 On rst at rising edge: head = tail = count = 0, all busy bits 0, uop_out_valid = 0, uop_out = all-zero; full = 0 in following cycle.
REQ-032 rst mid-operation discards all queued and in-flight uops; rst dominates en, enqueue, set and clear on the same edge.
REQ-033 Entry storage need not be cleared on reset; only pointers/count/valid are architecturally visible.

Verification
REQ-034 Empty queue, enqueue uop rs1=2, rs2=3 (not busy), exec_ready=1 -> uop_out_valid=1 after edge E+1, uop_out.rs1=2, count back to 0.
REQ-035 Set busy tag 5; enqueue uop rs1=5, then uop rs1=2 -> neither issues; pulse wb_en wb_addr=5 -> first issues that edge (bypass), second next edge, order preserved.
REQ-036 exec_ready=0, enqueue IQ_DEPTH+1 ready uops -> first in uop_out, remaining IQ_DEPTH-1 queued... continue until full=1 at count=8; extra uop dropped; release exec_ready -> exactly accepted uops issue in order, pointers wrap.
REQ-037 Same edge busy_table_wr_en tag 7 and wb_en tag 7 -> busy[7]=1; busy_table_wr_en tag 0 -> uop with rs1=0 issues immediately.
REQ-038 Queue with 3 entries and uop_out_valid=1, assert rst one cycle -> uop_out_valid=0, full=0, all busy clear, subsequent uop issues with min latency.
REQ-039 en=0 with ready head and exec_ready=1 -> no enqueue, no issue, uop_out_valid unchanged; en=1 resumes.

Source files
------------

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg / issue_queue
//
// Purpose
//   In-order issue queue between the rename/map stage and execute. Renamed
//   uops are held in a circular FIFO; the head uop issues once both of its
//   source operands are ready according to an internal busy table of
//   physical registers. A writeback broadcast in the same cycle counts as
//   ready (bypass), so a dependent head uop issues on the writeback edge.
//
// Ports
//   clk                 in   clock, all state updates on the rising edge
//   rst                 in   synchronous, active-high reset
//   en                  in   stage enable; 0 freezes enqueue and issue
//   uop_in              in   renamed uop from the map stage
//   uop_in_valid        in   uop_in carries a uop this cycle
//   full                out  queue holds IQ_DEPTH entries (map must stall)
//   busy_table_wr_en    in   mark busy_table_wr_addr busy
//   busy_table_wr_addr  in   physical tag to mark busy
//   wb_en               in   writeback broadcast, clears busy bit of wb_addr
//   wb_addr             in   physical tag being written back
//   uop_out             out  issued uop (registered)
//   uop_out_valid       out  uop_out holds an issued uop
//   exec_ready          in   execute stage accepts uop_out this cycle
// -----------------------------------------------------------------------------

package issue_queue_pkg;

  // Register tag fields are sized for the largest supported register file;
  // the queue only looks at the low $clog2(PHY_RF_DEPTH) bits.
  typedef struct packed {
    logic [7:0] id;
    logic [3:0] op;
    logic [5:0] rd;
    logic [5:0] rs1;
    logic       rs1_valid;
    logic [5:0] rs2;
    logic       rs2_valid;
  } uop_t;

endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int PHY_RF_DEPTH = 16,
  parameter int IQ_DEPTH     = 8,
  localparam int TW          = $clog2(PHY_RF_DEPTH),
  localparam int TW_Q        = $clog2(IQ_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  uop_t          uop_in,
  input  logic          uop_in_valid,
  output logic          full,
  input  logic          busy_table_wr_en,
  input  logic [TW-1:0] busy_table_wr_addr,
  input  logic          wb_en,
  input  logic [TW-1:0] wb_addr,
  output uop_t          uop_out,
  output logic          uop_out_valid,
  input  logic          exec_ready
);

  localparam logic [TW_Q:0]   DEPTH_C = (TW_Q + 1)'(IQ_DEPTH);
  localparam logic [TW_Q-1:0] PTR_ONE = TW_Q'(1);
  localparam logic [TW_Q:0]   CNT_ONE = (TW_Q + 1)'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uop_t                  mem [IQ_DEPTH];
  logic [TW_Q-1:0]       head;
  logic [TW_Q-1:0]       tail;
  logic [TW_Q:0]         count;
  logic [PHY_RF_DEPTH-1:0] busy;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  uop_t                    head_uop;
  logic                    rs1_ready;
  logic                    rs2_ready;
  logic                    slot_free;
  logic                    enq;
  logic                    issue;
  logic [TW_Q:0]           count_next;
  logic [PHY_RF_DEPTH-1:0] busy_next;

  // An operand is ready if it is unused, not busy, or being written back
  // this very cycle (the busy bit clears on the same edge the uop issues).
  function automatic logic src_ready(
    input logic                    used,
    input logic [TW-1:0]           tag,
    input logic [PHY_RF_DEPTH-1:0] busy_bits,
    input logic                    wb_hit_en,
    input logic [TW-1:0]           wb_tag
  );
    return !used || !busy_bits[tag] || (wb_hit_en && (wb_tag == tag));
  endfunction

  assign full     = (count == DEPTH_C);
  assign head_uop = mem[head];

  always_comb begin
    rs1_ready  = src_ready(head_uop.rs1_valid, head_uop.rs1[TW-1:0], busy,
                           wb_en, wb_addr);
    rs2_ready  = src_ready(head_uop.rs2_valid, head_uop.rs2[TW-1:0], busy,
                           wb_en, wb_addr);
    slot_free  = !uop_out_valid || exec_ready;

    // The entering uop is written at tail; issue looks only at the current
    // head, so a uop enqueued this edge cannot issue before the next edge
    // (when count was 0, head_uop is stale and issue is blocked by count).
    enq        = en && uop_in_valid && !full;
    issue      = en && (count != '0) && rs1_ready && rs2_ready && slot_free;

    count_next = count;
    case ({enq, issue})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Busy table next state: clear first so a same-tag set wins; tag 0 is
  // hard-wired not busy. Busy updates are independent of en.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[wb_addr] = 1'b0;
    end
    if (busy_table_wr_en) begin
      busy_next[busy_table_wr_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Entry storage (no reset: only pointers and count are visible)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      mem[tail] <= uop_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, busy table and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      uop_out       <= '0;
      uop_out_valid <= 1'b0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
      if (enq) begin
        tail <= tail + PTR_ONE;
      end
      if (issue) begin
        head          <= head + PTR_ONE;
        uop_out       <= head_uop;
        uop_out_valid <= 1'b1;
      end else if (en && exec_ready && uop_out_valid) begin
        // Consumed with nothing to replace it; data is held.
        uop_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//
// Directed bench for issue_queue. Stimulus pushes every uop it expects to be
// issued into a scoreboard queue; a monitor on the falling edge pops and
// compares each newly presented uop_out. Directed timing checks (valid,
// full, reset values) are made from the stimulus process.
// -----------------------------------------------------------------------------
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int PHY_RF_DEPTH = 16;
  localparam int IQ_DEPTH     = 8;
  localparam int TW           = $clog2(PHY_RF_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  uop_t          uop_in;
  logic          uop_in_valid;
  logic          full;
  logic          busy_table_wr_en;
  logic [TW-1:0] busy_table_wr_addr;
  logic          wb_en;
  logic [TW-1:0] wb_addr;
  uop_t          uop_out;
  logic          uop_out_valid;
  logic          exec_ready;

  int checks = 0;
  int errors = 0;

  uop_t sb[$];

  issue_queue #(
    .PHY_RF_DEPTH(PHY_RF_DEPTH),
    .IQ_DEPTH    (IQ_DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .uop_in            (uop_in),
    .uop_in_valid      (uop_in_valid),
    .full              (full),
    .busy_table_wr_en  (busy_table_wr_en),
    .busy_table_wr_addr(busy_table_wr_addr),
    .wb_en             (wb_en),
    .wb_addr           (wb_addr),
    .uop_out           (uop_out),
    .uop_out_valid     (uop_out_valid),
    .exec_ready        (exec_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic uop_t mk(input logic [7:0] id, input logic [5:0] rs1,
                              input logic rs1v, input logic [5:0] rs2,
                              input logic rs2v);
    uop_t u;
    u           = '0;
    u.id        = id;
    u.op        = id[3:0];
    u.rd        = 6'(id[4:0] + 5'd1);
    u.rs1       = rs1;
    u.rs1_valid = rs1v;
    u.rs2       = rs2;
    u.rs2_valid = rs2v;
    return u;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input uop_t u, input bit accept);
    uop_in       = u;
    uop_in_valid = 1'b1;
    if (accept) sb.push_back(u);
    step();
    uop_in_valid = 1'b0;
  endtask

  // Monitor: a new output is a rising valid or a change of id while valid
  // (every uop in this bench carries a unique id).
  logic       prev_valid = 1'b0;
  logic [7:0] prev_id    = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (uop_out_valid && (!prev_valid || uop_out.id != prev_id)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got uop id %0h, expected none at %0t",
                   uop_out.id, $time);
        end else begin
          uop_t e;
          e = sb.pop_front();
          if (uop_out !== e) begin
            errors++;
            $display("FAIL sb_uop: got %0h expected %0h at %0t",
                     uop_out, e, $time);
          end
        end
      end
      prev_valid = uop_out_valid;
      prev_id    = uop_out.id;
    end
  end

  initial begin
    rst                = 1'b1;
    en                 = 1'b1;
    uop_in             = '0;
    uop_in_valid       = 1'b0;
    busy_table_wr_en   = 1'b0;
    busy_table_wr_addr = '0;
    wb_en              = 1'b0;
    wb_addr            = '0;
    exec_ready         = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_valid", uop_out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_uop_out", uop_out, 0);

    // Minimum latency from empty queue
    send(mk(8'h01, 6'd2, 1'b1, 6'd3, 1'b1), 1'b1);
    chk("lat_e", uop_out_valid, 0);
    step();
    chk("lat_e1_valid", uop_out_valid, 1);
    chk("lat_e1_rs1", uop_out.rs1, 2);
    step();
    chk("lat_drain", uop_out_valid, 0);

    // Busy tag 5 blocks head and younger entry; writeback bypass releases
    busy_table_wr_en   = 1'b1;
    busy_table_wr_addr = 4'd5;
    step();
    busy_table_wr_en   = 1'b0;
    send(mk(8'h02, 6'd5, 1'b1, 6'd0, 1'b0), 1'b1);
    send(mk(8'h03, 6'd2, 1'b1, 6'd0, 1'b0), 1'b1);
    step();
    chk("busy_block", uop_out_valid, 0);
    wb_en   = 1'b1;
    wb_addr = 4'd5;
    step();
    wb_en   = 1'b0;
    chk("bypass_valid", uop_out_valid, 1);
    chk("bypass_id", uop_out.id, 8'h02);
    step();
    chk("order_id", uop_out.id, 8'h03);
    step();
    chk("busy_drain", uop_out_valid, 0);

    // Fill to full with output stalled; the tenth uop is dropped
    exec_ready = 1'b0;
    for (int i = 0; i < IQ_DEPTH + 2; i++) begin
      if (i == IQ_DEPTH)     chk("fill_not_full", full, 0);
      if (i == IQ_DEPTH + 1) chk("fill_full", full, 1);
      send(mk(8'(8'h10 + i), 6'(i % 16), 1'b1, 6'd3, 1'b1), i <= IQ_DEPTH);
    end
    chk("fill_still_full", full, 1);
    chk("fill_head_out", uop_out.id, 8'h10);
    exec_ready = 1'b1;
    for (int i = 0; i < IQ_DEPTH + 1; i++) step();
    chk("fill_drain_valid", uop_out_valid, 0);
    chk("fill_drain_full", full, 0);
    chk("fill_sb_empty", sb.size(), 0);

    // Tag 0 can never be made busy
    busy_table_wr_en   = 1'b1;
    busy_table_wr_addr = 4'd0;
    step();
    busy_table_wr_en   = 1'b0;
    send(mk(8'h20, 6'd0, 1'b1, 6'd0, 1'b1), 1'b1);
    step();
    chk("tag0_issue", uop_out_valid, 1);
    step();

    // Same-edge set and clear of tag 7: set wins
    busy_table_wr_en   = 1'b1;
    busy_table_wr_addr = 4'd7;
    wb_en              = 1'b1;
    wb_addr            = 4'd7;
    step();
    busy_table_wr_en   = 1'b0;
    wb_en              = 1'b0;
    send(mk(8'h21, 6'd7, 1'b1, 6'd0, 1'b0), 1'b1);
    step();
    step();
    chk("setwins_blocked", uop_out_valid, 0);
    wb_en   = 1'b1;
    wb_addr = 4'd7;
    step();
    wb_en   = 1'b0;
    chk("setwins_release", uop_out_valid, 1);
    step();

    // Reset mid-operation with queued uops and a busy tag
    busy_table_wr_en   = 1'b1;
    busy_table_wr_addr = 4'd9;
    step();
    busy_table_wr_en   = 1'b0;
    exec_ready         = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(8'(8'h30 + i), 6'd1, 1'b1, 6'd2, 1'b1), 1'b1);
    chk("pre_rst_valid", uop_out_valid, 1);
    sb.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", uop_out_valid, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_uop_out", uop_out, 0);
    exec_ready = 1'b1;
    send(mk(8'h38, 6'd9, 1'b1, 6'd0, 1'b0), 1'b1);
    chk("post_rst_e", uop_out_valid, 0);
    step();
    chk("post_rst_e1", uop_out_valid, 1);
    step();

    // Stage enable low freezes everything even with exec_ready high
    exec_ready = 1'b0;
    send(mk(8'h40, 6'd1, 1'b1, 6'd0, 1'b0), 1'b1);
    send(mk(8'h41, 6'd2, 1'b1, 6'd0, 1'b0), 1'b1);
    chk("en_pre_id", uop_out.id, 8'h40);
    en           = 1'b0;
    exec_ready   = 1'b1;
    uop_in       = mk(8'h42, 6'd3, 1'b1, 6'd0, 1'b0);
    uop_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    uop_in_valid = 1'b0;
    chk("en0_valid", uop_out_valid, 1);
    chk("en0_id", uop_out.id, 8'h40);
    en = 1'b1;
    step();
    chk("en1_resume_id", uop_out.id, 8'h41);
    step();
    chk("en1_drain", uop_out_valid, 0);
    step();
    step();
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
